// File: rtl/cache_pkg.sv
// Shared cache definitions: line geometry and the refill controller's state encoding.
package cache_pkg;

  localparam int CACHE_LINE_WORDS = 4;
  localparam int WORD_BYTE_BITS   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl_line_buffer.sv
// Line assembly buffer: one register per word, asynchronously cleared, written
// one word at a time and presented as a packed line.
module line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [$clog2(LINE_WORDS)-1:0]    idx,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] line_data
);

  logic [DATA_WIDTH-1:0] word_q [LINE_WORDS];
  logic [DATA_WIDTH-1:0] word_d [LINE_WORDS];

  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++) word_d[i] = word_q[i];
    if (we) word_d[idx] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) word_q[i] <= '0;
    end else begin
      for (int i = 0; i < LINE_WORDS; i++) word_q[i] <= word_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++) line_data[i*DATA_WIDTH +: DATA_WIDTH] = word_q[i];
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill / write-back controller: optional dirty-victim write-back,
// then a word-by-word line fetch, returned to the cache in a single response pulse.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = CACHE_LINE_WORDS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_dirty,
  input  logic                             req_fill,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [ADDR_WIDTH-1:0]            req_victim_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
  output logic                             resp_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_rdata,
  output logic                             busy,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_ack,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFFS_W = BEAT_W + WORD_BYTE_BITS;
  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((64'd1 << OFFS_W) - 64'd1);

  refill_state_t         state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] fill_base_q, fill_base_d;
  logic [ADDR_WIDTH-1:0] victim_base_q, victim_base_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] beat_offs;
  logic [DATA_WIDTH-1:0] victim_word [LINE_WORDS];
  logic                  buf_we;

  // Next-state: beat wraps back to 0 after the last word, ready for the next phase.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    fill_d        = fill_q;
    fill_base_d   = fill_base_q;
    victim_base_d = victim_base_q;
    wdata_d       = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          fill_base_d   = req_addr & ~OFFS_MASK;
          victim_base_d = req_victim_addr & ~OFFS_MASK;
          wdata_d       = req_wdata;
          fill_d        = req_fill;
          beat_d        = '0;
          if (req_dirty)     state_d = WB;
          else if (req_fill) state_d = FILL;
          else               state_d = RESP;
        end
      end
      WB: begin
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = fill_q ? FILL : RESP;
        end
      end
      FILL: begin
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fill_q  <= fill_d;
    end
  end

  // Request payload only matters once a request is accepted, so it carries no reset.
  always_ff @(posedge clk) begin
    fill_base_q   <= fill_base_d;
    victim_base_q <= victim_base_d;
    wdata_q       <= wdata_d;
  end

  assign beat_offs = ADDR_WIDTH'({beat_q, {WORD_BYTE_BITS{1'b0}}});

  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++) victim_word[i] = wdata_q[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Memory outputs decode straight from state so an async reset drops mem_req at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = victim_base_q + beat_offs;
        mem_wdata = victim_word[beat_q];
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = fill_base_q + beat_offs;
      end
      default: ;
    endcase
  end

  assign buf_we     = (state_q == FILL) && mem_ack;
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign req_ready  = (state_q == IDLE);

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .we        (buf_we),
    .idx       (beat_q),
    .wdata     (mem_rdata),
    .line_data (resp_rdata)
  );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed vector table, hand-built corner sequences
// and randomized operations against a transaction-level memory/line model.
module tb_cache_refill_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int LB = LW * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid, req_ready, req_dirty, req_fill;
  logic [AW-1:0] req_addr, req_victim_addr;
  logic [LB-1:0] req_wdata, resp_rdata;
  logic          resp_valid, busy, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  cache_refill_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LINE_WORDS (LW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_dirty       (req_dirty),
    .req_fill        (req_fill),
    .req_addr        (req_addr),
    .req_victim_addr (req_victim_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .busy            (busy),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dirty;
    bit          fill;
    logic [AW-1:0] addr;
    logic [AW-1:0] vaddr;
    logic [LB-1:0] wdata;
    int          waits;      // fixed wait states per beat; negative = random per beat
    logic [DW-1:0] seed;     // memory contents selector
    bit          has_exp;
    logic [LB-1:0] exp_line;
    int          exp_cycles; // accept edge to resp_valid cycle
  } vec_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            wt;
  } acc_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] cur_seed;
  logic [LB-1:0] prev_line;

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory image: seed 0 gives 0xA0 + word-in-line, otherwise address xor seed.
  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (cur_seed == '0) return 32'hA0 + DW'((a % 16) / 4);
    return a ^ cur_seed;
  endfunction

  function automatic vec_t mk(input bit d, input bit f, input logic [AW-1:0] a,
                              input logic [AW-1:0] va, input logic [LB-1:0] wd,
                              input int w, input logic [DW-1:0] s, input bit he,
                              input logic [LB-1:0] el, input int ec);
    vec_t v;
    v.dirty = d; v.fill = f; v.addr = a; v.vaddr = va; v.wdata = wd; v.waits = w;
    v.seed = s; v.has_exp = he; v.exp_line = el; v.exp_cycles = ec;
    return v;
  endfunction

  // Present one request at a negedge and follow it to completion; abort >= 0
  // asserts rst once that many acks have been given and returns with rst high.
  task automatic run_op(input vec_t v, input bit hold, input int abort);
    acc_t          q[$];
    acc_t          a;
    logic [AW-1:0] fbase, vbase;
    logic [LB-1:0] exp_line;
    int            exp_cyc, cyc, acks, wcnt;
    bit            done;

    cur_seed = v.seed;
    fbase    = v.addr - (v.addr % 16);
    vbase    = v.vaddr - (v.vaddr % 16);
    exp_line = prev_line;
    exp_cyc  = 1;
    if (v.dirty) begin
      for (int i = 0; i < LW; i++) begin
        a.we = 1'b1; a.addr = vbase + 4 * i; a.data = v.wdata[i*DW +: DW];
        a.wt = (v.waits < 0) ? int'($urandom_range(0, 2)) : v.waits;
        exp_cyc += a.wt + 1;
        q.push_back(a);
      end
    end
    if (v.fill) begin
      for (int i = 0; i < LW; i++) begin
        a.we = 1'b0; a.addr = fbase + 4 * i; a.data = mem_read(fbase + 4 * i);
        a.wt = (v.waits < 0) ? int'($urandom_range(0, 2)) : v.waits;
        exp_cyc += a.wt + 1;
        exp_line[i*DW +: DW] = a.data;
        q.push_back(a);
      end
    end
    if (v.has_exp) begin
      exp_line = v.exp_line;
      exp_cyc  = v.exp_cycles;
    end

    req_dirty = v.dirty; req_fill = v.fill; req_addr = v.addr;
    req_victim_addr = v.vaddr; req_wdata = v.wdata; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    cyc = 0; acks = 0; wcnt = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!hold) req_valid = 1'b0;
      mem_ack = 1'b0;
      if (abort >= 0 && acks == abort) begin
        rst = 1'b1;
        #1;
        chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_resp_valid", resp_valid, 1'b0);
        chk("abort_resp_rdata", resp_rdata, '0);
        prev_line = '0;
        return;
      end
      chk("busy_during_op", busy, 1'b1);
      chk("mem_req", mem_req, q.size() != 0);
      if (resp_valid) begin
        chk("resp_cycle", cyc, exp_cyc);
        chk("resp_rdata", resp_rdata, exp_line);
        done = 1'b1;
      end else if (mem_req && q.size() != 0) begin
        chk("mem_we", mem_we, q[0].we);
        chk("mem_addr", mem_addr, q[0].addr);
        if (q[0].we) chk("mem_wdata", mem_wdata, q[0].data);
        if (wcnt == q[0].wt) begin
          mem_ack   = 1'b1;
          mem_rdata = q[0].we ? DW'($urandom) : mem_read(mem_addr);
          void'(q.pop_front());
          acks++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid after %0d cycles, expected one at %0d", cyc, exp_cyc);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    chk("resp_one_cycle", resp_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_req_ready", req_ready, 1'b1);
    prev_line = exp_line;
  endtask

  initial begin
    vec_t tbl[5];
    vec_t v;
    logic [LB-1:0] a_line;

    req_valid = 1'b0; req_dirty = 1'b0; req_fill = 1'b0; req_addr = '0;
    req_victim_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    cur_seed = '0; prev_line = '0;
    a_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    tbl[0] = mk(0, 1, 32'h0000_1234, 32'h0, '0, 0, 32'h0, 1, a_line, 5);
    tbl[1] = mk(1, 0, 32'h0000_0000, 32'h0000_5004,
                {32'h24, 32'h23, 32'h22, 32'h21}, 0, 32'h0, 1, a_line, 5);
    tbl[2] = mk(1, 1, 32'h0000_3008, 32'h0000_2000,
                {32'h14, 32'h13, 32'h12, 32'h11}, 0, 32'h5A5A_0000, 1,
                {32'h5A5A_300C, 32'h5A5A_3008, 32'h5A5A_3004, 32'h5A5A_3000}, 9);
    tbl[3] = mk(0, 1, 32'h0000_4010, 32'h0, '0, 3, 32'h0, 1, a_line, 17);
    tbl[4] = mk(0, 1, 32'hFFFF_FFFF, 32'h0, '0, 1, 32'h0F0F_0000, 1,
                {32'hF0F0_FFFC, 32'hF0F0_FFF8, 32'hF0F0_FFF4, 32'hF0F0_FFF0}, 9);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_resp_rdata", resp_rdata, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i], 1'b0, -1);
      if (i == 0) begin
        // Stray acks while idle must not start anything or touch the line.
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("spurious_busy", busy, 1'b0);
          chk("spurious_mem_req", mem_req, 1'b0);
          chk("spurious_resp_rdata", resp_rdata, prev_line);
        end
        mem_ack = 1'b0;
      end
    end

    // req_valid held across a whole operation: one accept, then a fresh one after RESP.
    v = mk(0, 1, 32'h0000_6004, 32'h0, '0, 0, 32'h0, 1, a_line, 5);
    run_op(v, 1'b1, -1);
    run_op(v, 1'b0, -1);

    // Reset after two fill beats, then recovery.
    v = mk(0, 1, 32'h0000_7000, 32'h0, '0, 0, 32'h3333_0000, 0, '0, 0);
    run_op(v, 1'b0, 2);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_hold_busy", busy, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_resp", resp_valid, 1'b0);
    end
    run_op(v, 1'b0, -1);

    for (int n = 0; n < 24; n++) begin
      v = mk(1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
             {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)},
             -1, DW'($urandom) | 32'h1, 0, '0, 0);
      run_op(v, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Line-refill and write-back controller between the data cache and a word-wide, variable-latency main memory.
- On a cache miss it optionally writes back the dirty victim line, then fetches the missing line word by word.
- It returns the assembled line to the cache in one response pulse.
- Sits directly downstream of the cache; the core stalls while `busy` is high.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, memory word width in bits.
- LINE_WORDS, 4, words per cache line; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  cache requests a line operation.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_dirty  in  1  write back victim line first.
- req_fill  in  1  fetch the line at req_addr.
- req_addr  in  ADDR_WIDTH  miss address (any byte within the line).
- req_victim_addr  in  ADDR_WIDTH  victim line address (any byte within the line).
- req_wdata  in  LINE_WORDS*DATA_WIDTH  victim line data; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- resp_valid  out  1  one-cycle pulse: operation complete.
- resp_rdata  out  LINE_WORDS*DATA_WIDTH  filled line, same packing; held until the next fill completes.
- busy  out  1  state != IDLE.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_ack  in  1  memory completes current access.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.

Behaviour:
- Reset is asynchronous and active-high, on port rst; single clock clk.
- Reset values:
  - state = IDLE, beat = 0.
  - line buffer = 0; all mem_* outputs = 0.
  - resp_valid = 0, busy = 0, req_ready = 1.
- Reset mid-operation aborts immediately; mem_req drops asynchronously and no resp_valid is issued.
- FSM states: IDLE, WB, FILL, RESP.
- IDLE: req_ready = 1. A request is accepted on `req_valid && req_ready` at a clock edge. On acceptance:
  - Latch both addresses with the low log2(LINE_WORDS)+2 bits cleared (line base).
  - Latch req_wdata, req_fill and req_dirty.
  - Clear beat.
  - Next state: WB if req_dirty; else FILL if req_fill; else RESP.
- WB:
  - Outputs: mem_req = 1, mem_we = 1, mem_addr = victim_base + 4*beat, mem_wdata = victim word[beat].
  - Outputs stay stable until the cycle mem_ack = 1.
  - On ack: if beat == LINE_WORDS-1, clear beat and go to FILL (if the latched fill = 1) or RESP; else beat++.
- FILL:
  - Outputs: mem_req = 1, mem_we = 0, mem_addr = fill_base + 4*beat.
  - On ack: buffer[beat] <= mem_rdata.
  - At the last beat go to RESP; else beat++.
- RESP: resp_valid = 1 for exactly one cycle; next state is IDLE.
- resp_rdata is driven from the line buffer:
  - It updates only during FILL.
  - For a write-back-only operation it keeps its prior contents.
- Memory handshake:
  - mem_ack may arrive in the same cycle mem_req rises (zero wait state) or after any number of wait cycles.
  - mem_ack while mem_req = 0 is ignored.
  - mem_req never deasserts between consecutive beats of the same phase. The address advances on the cycle after ack.
- Latency (zero-wait memory): 1 cycle per beat.
  - Fill only: accept edge, then LINE_WORDS FILL cycles, then 1 RESP cycle.
  - Dirty + fill: an additional LINE_WORDS cycles.
- A request asserted while busy is not accepted; the cache must hold req_valid and its payload.
- beat counter width is log2(LINE_WORDS); address adds wrap modulo 2^ADDR_WIDTH.

Decomposition:
- Shared package `cache_pkg`:
  - State enum `refill_state_t` {IDLE, WB, FILL, RESP}.
  - LINE_WORDS / word-offset constants, shared with the cache.
- One sub-module: `line_buffer`, a LINE_WORDS x DATA_WIDTH register array with async clear, indexed write enable, and packed output.
- FSM and beat counter live in the top of this block.

Test Plan:
- Fill only, zero-wait mem, req_addr 0x0000_1234 → mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - mem_rdata 0xA0..0xA3 → resp_rdata = {0xA3, 0xA2, 0xA1, 0xA0}.
  - resp_valid exactly 1 cycle, 5 cycles after accept.
- Dirty + fill, victim 0x0000_2000, req_wdata words 0x11..0x14:
  - 4 writes to 0x2000–0x200C carrying 0x11..0x14, then 4 reads from the fill line.
  - busy is continuously high throughout.
- Wait states: mem_ack delayed 3 cycles per beat → mem_addr/mem_wdata stable during each wait; 16 FILL cycles total; correct data.
- Write-back only (dirty = 1, fill = 0) after the first test:
  - resp_valid after the 4th write.
  - resp_rdata unchanged = {0xA3..0xA0}.
- Reset asserted mid-FILL (after beat 1) → mem_req = 0 and busy = 0 without a clock edge; resp_rdata = 0; no resp_valid.
  - A new request afterwards completes normally.
- Protocol misuse:
  - Spurious mem_ack in IDLE → no state change.
  - req_valid held while busy → accepted only on the cycle after RESP (req_ready = 1).
